// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte-stream requesters.
// Round-robin grant, locked to one requester until its last byte or a hold timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int HOLD_TIMEOUT = 64,
    parameter int TIMEOUT_W    = 7
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_data,
    input  logic [NUM_REQ-1:0]   i_last,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [ID_W-1:0]      o_grant_id,
    output logic                 o_active,
    output logic                 o_timeout,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done
);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, HOLD} state_t;

    localparam logic [ID_W-1:0]      LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]        NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX   = TIMEOUT_W'(HOLD_TIMEOUT - 1);

    state_t               state;
    logic [ID_W-1:0]      ptr;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 last_reg;

    logic [ID_W:0]        scan;
    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [ID_W-1:0]      sel_id;
    logic                 sel_ok;
    logic [NUM_REQ-1:0]   sel_ack;
    logic [7:0]           sel_data;
    logic                 sel_last;
    logic                 capture;
    logic [ID_W-1:0]      next_ptr;

    // Scan from the farthest offset down so the nearest set bit after ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = {1'b0, ptr} + (ID_W + 1)'(k);
            if (scan >= NUM_REQ_W) begin
                scan = scan - NUM_REQ_W;
            end
            if (i_req[scan[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan[ID_W-1:0];
            end
        end
    end

    // In HOLD only the current owner may supply the next byte.
    always_comb begin
        sel_id  = (state == HOLD) ? o_grant_id : win_id;
        sel_ok  = (state == HOLD) ? i_req[o_grant_id] : win_found;
        sel_ack = '0;
        sel_ack[sel_id] = 1'b1;
        sel_data = i_data[{sel_id, 3'b000} +: 8];
        sel_last = i_last[sel_id];
        capture  = ((state == IDLE) || (state == HOLD)) && sel_ok && !i_tx_busy;
        next_ptr = (o_grant_id == LAST_ID) ? '0 : o_grant_id + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            o_ack      <= '0;
            o_grant_id <= '0;
            o_active   <= 1'b0;
            o_timeout  <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            o_ack      <= '0;
            o_timeout  <= 1'b0;
            o_tx_start <= 1'b0;
            if (capture) begin
                state      <= START;
                o_ack      <= sel_ack;
                o_grant_id <= sel_id;
                o_active   <= 1'b1;
                o_tx_start <= 1'b1;
                o_tx_data  <= sel_data;
                cnt        <= '0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    START: state <= WAIT_DONE;
                    WAIT_DONE: begin
                        if (i_tx_done) begin
                            if (last_reg) begin
                                state    <= IDLE;
                                ptr      <= next_ptr;
                                o_active <= 1'b0;
                            end else begin
                                state <= HOLD;
                                cnt   <= '0;
                            end
                        end
                    end
                    HOLD: begin
                        if (cnt == CNT_MAX) begin
                            state     <= IDLE;
                            ptr       <= next_ptr;
                            o_active  <= 1'b0;
                            o_timeout <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (capture) begin
            last_reg <= sel_last;
        end
    end

endmodule
